// File: rtl/com_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : com_uart_tx
// Description : Captures bytes strobed by the interpreter COM port (com_clk /
//               com_data), buffers them in a FIFO and transmits them LSB-first
//               as UART frames on tx (8N1, or 8E1 when COM_UART_PARITY_EN is
//               defined).
// Revision    : 1.0 - initial release
// ============================================================================
module com_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          com_clk,
  input  logic [7:0]                    com_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   RELOAD   = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef COM_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic          s1_clk_q, s2_clk_q;
  logic [7:0]    s1_data_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [2:0]    state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
`ifdef COM_UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic push_req, push_ok, full, pop, timer_done;

  // One push per rising edge of the registered strobe; fullness uses the
  // pre-cycle count so a same-cycle pop never rescues a push.
  always_comb begin
    push_req   = s1_clk_q & ~s2_clk_q;
    full       = (count_q == FULL_CNT);
    push_ok    = push_req & ~full;
    overflow_d = overflow_q | (push_req & full);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    timer_done = (timer_q == 16'd0);
`ifdef COM_UART_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 3'd0;
          timer_d   = RELOAD;
          state_d   = S_START;
`ifdef COM_UART_PARITY_EN
          parity_d  = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (timer_done) begin
          timer_d = RELOAD;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (timer_done) begin
          timer_d = RELOAD;
          if (bit_cnt_q == 3'd7) begin
`ifdef COM_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`ifdef COM_UART_PARITY_EN
      S_PARITY: begin
        if (timer_done) begin
          timer_d = RELOAD;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (timer_done) begin
          timer_d = RELOAD;
          // Chain straight into the next start bit when bytes are waiting.
          if (count_q != '0) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_cnt_d = 3'd0;
            state_d   = S_START;
`ifdef COM_UART_PARITY_EN
            parity_d  = ^mem_q[rd_ptr_q];
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);

    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
`ifdef COM_UART_PARITY_EN
    else if (state_d == S_PARITY) tx_d = parity_d;
`endif

    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_clk_q   <= 1'b0;
      s2_clk_q   <= 1'b0;
      s1_data_q  <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      timer_q    <= RELOAD;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef COM_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      s1_clk_q   <= com_clk;
      s2_clk_q   <= s1_clk_q;
      s1_data_q  <= com_data;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef COM_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= s1_data_q;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_com_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_com_uart_tx
// Description : Self-checking bench for com_uart_tx; a queue-based model of
//               push/pop timing predicts frame contents and start cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_com_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef COM_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * C;

  logic       clk = 1'b0;
  logic       reset;
  logic       com_clk;
  logic [7:0] com_data;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  com_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .com_clk    (com_clk),
    .com_data   (com_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Model state: pending bytes with their write edge, and predicted frames.
  int mq_b[$];
  int mq_t[$];
  int avail    = 0;
  int exp_ovf  = 0;
  int peak_exp = 0;
  int exp_byte[$];
  int exp_start[$];

  // Line receiver observations.
  int got_byte[$];
  int got_start[$];
  int got_ok[$];
  bit mon_act = 1'b0;
  int mon_start, mon_ok, off;
  logic [7:0] mon_byte;
  int peak_obs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pop_edge();
    return (avail > mq_t[0] + 1) ? avail : mq_t[0] + 1;
  endfunction

  task automatic model_pop();
    int e;
    e = pop_edge();
    exp_byte.push_back(mq_b.pop_front());
    exp_start.push_back(e);
    void'(mq_t.pop_front());
    avail = e + FRAME;
  endtask

  task automatic model_push(input int t, input int b);
    bit was_full;
    while (mq_b.size() > 0 && pop_edge() < t) model_pop();
    was_full = (mq_b.size() == DEPTH);
    if (mq_b.size() > 0 && pop_edge() == t) model_pop();
    if (was_full) exp_ovf = 1;
    else begin
      mq_b.push_back(b);
      mq_t.push_back(t);
      if (mq_b.size() > peak_exp) peak_exp = mq_b.size();
    end
  endtask

  task automatic model_reset();
    mq_b.delete(); mq_t.delete(); exp_byte.delete(); exp_start.delete();
    avail = 0; exp_ovf = 0; peak_exp = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) mon_act = 1'b0;
    else begin
      if (32'(fifo_count) > peak_obs) peak_obs = 32'(fifo_count);
      if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1'b1; mon_start = cyc; mon_ok = 1; mon_byte = 8'd0;
        end
      end else begin
        off = cyc - mon_start;
        if (off == C/2 && tx !== 1'b0) mon_ok = 0;
        for (int i = 0; i < 8; i++)
          if (off == (i + 1) * C + C/2) mon_byte[i] = tx;
`ifdef COM_UART_PARITY_EN
        if (off == 9 * C + C/2 && tx !== ^mon_byte) mon_ok = 0;
`endif
        if (off == (FRAME_BITS - 1) * C + C/2) begin
          if (tx !== 1'b1) mon_ok = 0;
          got_byte.push_back(32'(mon_byte));
          got_start.push_back(mon_start);
          got_ok.push_back(mon_ok);
          mon_act = 1'b0;
        end
      end
    end
  end

  // Called at #1 after an edge; strobe high for h cycles, then low for l.
  task automatic strobe(input logic [7:0] b, input int h, input int l);
    com_clk  = 1'b1;
    com_data = b;
    model_push(cyc + 2, 32'(b));
    repeat (h) begin @(posedge clk); #1; end
    com_clk = 1'b0;
    repeat (l) begin @(posedge clk); #1; end
  endtask

  task automatic check_drain(input string tag);
    int deadline, n;
    while (mq_b.size() > 0) model_pop();
    deadline = (exp_start.size() > 0) ? exp_start[$] + FRAME + 4 : cyc + FRAME + 4;
    while (cyc < deadline) begin @(posedge clk); #1; end
    chk({tag, "_nframes"}, got_byte.size(), exp_byte.size());
    n = (got_byte.size() < exp_byte.size()) ? got_byte.size() : exp_byte.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got_byte[i], exp_byte[i]);
      chk($sformatf("%s_start%0d", tag, i), got_start[i], exp_start[i]);
      chk($sformatf("%s_frame%0d", tag, i), got_ok[i], 1);
    end
    chk({tag, "_tx_idle"}, 32'(tx), 1);
    chk({tag, "_busy_idle"}, 32'(busy), 0);
    chk({tag, "_count_idle"}, 32'(fifo_count), 0);
    exp_byte.delete(); exp_start.delete();
    got_byte.delete(); got_start.delete(); got_ok.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    got_byte.delete(); got_start.delete(); got_ok.delete();
    peak_obs = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drv;
    reset = 1'b0; com_clk = 1'b0; com_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single byte, first start bit three cycles after the strobe is driven.
    drv = cyc;
    strobe(8'hA5, 1, 1);
    while (cyc < drv + 8) begin @(posedge clk); #1; end
    chk("a5_busy_mid", 32'(busy), 1);
    chk("a5_latency", (got_start.size() == 0 && mon_act) ? mon_start - drv : -1, 3);
    check_drain("single");

    // Back-to-back frames.
    peak_obs = 0; peak_exp = 0;
    strobe(8'h01, 1, 1);
    strobe(8'h80, 1, 1);
    strobe(8'hFF, 1, 1);
    check_drain("b2b");
    chk("b2b_peak", peak_obs, 2);
    chk("b2b_peak_model", peak_obs, peak_exp);

    // Held strobe gives one frame only.
    strobe(8'h3C, 20, 2);
    check_drain("held");

    // Parity patterns (odd and even popcount).
    strobe(8'h07, 1, 1);
    strobe(8'h03, 1, 1);
    check_drain("par");

    // Overflow: seven strobes two cycles apart into a four-slot FIFO.
    chk("ovf_pre", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) strobe(8'($urandom_range(0, 255)), 1, 1);
    check_drain("ovf");
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_model", 32'(overflow), exp_ovf);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_sticky", 32'(overflow), 1);
    do_reset();
    chk("ovf_cleared", 32'(overflow), 0);

    // Random bursts mixed with idle gaps.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0)
        strobe(8'($urandom_range(0, 255)), $urandom_range(1, 3), $urandom_range(1, 2));
      else
        strobe(8'($urandom_range(0, 255)), $urandom_range(1, 3), $urandom_range(30, 60));
    end
    check_drain("rnd");
    chk("rnd_ovf", 32'(overflow), exp_ovf);
    do_reset();

    // Reset during DATA with three bytes queued.
    for (int i = 0; i < 4; i++) strobe(8'($urandom_range(0, 255)), 1, 1);
    chk("mid_queued", 32'(fifo_count), 3);
    chk("mid_in_frame", 32'(mon_act), 1);
    reset = 1'b0;
    #1;
    chk("mid_tx", 32'(tx), 1);
    chk("mid_count", 32'(fifo_count), 0);
    chk("mid_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    got_byte.delete(); got_start.delete(); got_ok.delete();
    repeat (3 * FRAME) @(posedge clk);
    #1;
    chk("mid_noframe", got_byte.size(), 0);
    chk("mid_tx_after", 32'(tx), 1);
    chk("mid_busy_after", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
